// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage core: datapath widths, ALU opcodes and
// the forward-select encoding used between the hazard unit and operand muxes.
package cpu_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALUC_WIDTH     = 4;
    localparam int SHAMT_WIDTH    = 5;

    localparam logic [ALUC_WIDTH-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_WIDTH-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_WIDTH-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_WIDTH-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_WIDTH-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_WIDTH-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_WIDTH-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_WIDTH-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_WIDTH-1:0] ALUC_SRA = 4'b1111;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/cpu_mux.sv
// Generic operand multiplexers shared across the datapath.
module MUX_4x1_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_a2,
    input  logic [WIDTH-1:0] i_a3,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_y
);
    always_comb begin
        case (i_sel)
            2'b00:   o_y = i_a0;
            2'b01:   o_y = i_a1;
            2'b10:   o_y = i_a2;
            default: o_y = i_a3;
        endcase
    end
endmodule

module MUX_2x1_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_a1 : i_a0;
endmodule

// File: rtl/id_ex_stage_fwd_unit.sv
// Hazard comparators: picks the freshest producer for rs/rt and flags a
// load in EX whose result the decode-slot instruction needs right now.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
    input  logic                      i_d_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rt_addr,
    input  logic                      i_use_rs,
    input  logic                      i_use_rt,
    input  logic                      i_e_valid,
    input  logic                      i_e_wreg,
    input  logic                      i_e_m2reg,
    input  logic [REG_ADDR_WIDTH-1:0] i_e_rd,
    input  logic                      i_m_wreg,
    input  logic [REG_ADDR_WIDTH-1:0] i_m_rd,
    output fwd_sel_e                  o_rs_sel,
    output fwd_sel_e                  o_rt_sel,
    output logic                      o_load_use
);
    logic w_ex_alu_wr;
    logic w_ex_load_wr;
    logic w_m_wr;

    // A load in EX has no value yet, so it can only stall, never forward.
    assign w_ex_alu_wr  = i_e_valid & i_e_wreg & ~i_e_m2reg & (i_e_rd != '0);
    assign w_ex_load_wr = i_e_valid & i_e_wreg &  i_e_m2reg & (i_e_rd != '0);
    assign w_m_wr       = i_m_wreg & (i_m_rd != '0);

    always_comb begin
        o_rs_sel = FWD_REG;
        if (w_ex_alu_wr && (i_e_rd == i_rs_addr))
            o_rs_sel = FWD_EX;
        else if (w_m_wr && (i_m_rd == i_rs_addr))
            o_rs_sel = FWD_MEM;
    end

    always_comb begin
        o_rt_sel = FWD_REG;
        if (w_ex_alu_wr && (i_e_rd == i_rt_addr))
            o_rt_sel = FWD_EX;
        else if (w_m_wr && (i_m_rd == i_rt_addr))
            o_rt_sel = FWD_MEM;
    end

    assign o_load_use = i_d_valid & w_ex_load_wr &
                        ((i_use_rs & (i_e_rd == i_rs_addr)) |
                         (i_use_rt & (i_e_rd == i_rt_addr)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards EX/MEM results into the ALU operands and
// turns a load-use hazard into a single bubble while IF/ID is frozen.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
    parameter int ALUC_WIDTH     = cpu_pkg::ALUC_WIDTH,
    parameter int SHAMT_WIDTH    = cpu_pkg::SHAMT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      D_VALID,
    input  logic [DATA_WIDTH-1:0]     D_RS_DATA,
    input  logic [DATA_WIDTH-1:0]     D_RT_DATA,
    input  logic [REG_ADDR_WIDTH-1:0] D_RS_ADDR,
    input  logic [REG_ADDR_WIDTH-1:0] D_RT_ADDR,
    input  logic [REG_ADDR_WIDTH-1:0] D_RD_ADDR,
    input  logic                      D_USE_RS,
    input  logic                      D_USE_RT,
    input  logic [DATA_WIDTH-1:0]     D_IMM,
    input  logic [SHAMT_WIDTH-1:0]    D_SA,
    input  logic [ALUC_WIDTH-1:0]     D_ALUC,
    input  logic                      D_ALUIMM,
    input  logic                      D_SHIFT,
    input  logic                      D_WREG,
    input  logic                      D_M2REG,
    input  logic                      D_WMEM,
    input  logic [DATA_WIDTH-1:0]     EX_RESULT,
    input  logic                      M_WREG,
    input  logic [REG_ADDR_WIDTH-1:0] M_RD,
    input  logic [DATA_WIDTH-1:0]     M_RESULT,
    input  logic                      FLUSH,
    input  logic                      HOLD,
    output logic                      STALL,
    output logic                      E_VALID,
    output logic [DATA_WIDTH-1:0]     E_A,
    output logic [DATA_WIDTH-1:0]     E_B,
    output logic [DATA_WIDTH-1:0]     E_STORE_DATA,
    output logic [ALUC_WIDTH-1:0]     E_ALUC,
    output logic                      E_WREG,
    output logic                      E_M2REG,
    output logic                      E_WMEM,
    output logic [REG_ADDR_WIDTH-1:0] E_RD
);
    logic                      r_valid;
    logic [DATA_WIDTH-1:0]     r_a;
    logic [DATA_WIDTH-1:0]     r_b;
    logic [DATA_WIDTH-1:0]     r_store_data;
    logic [ALUC_WIDTH-1:0]     r_aluc;
    logic                      r_wreg;
    logic                      r_m2reg;
    logic                      r_wmem;
    logic [REG_ADDR_WIDTH-1:0] r_rd;

    fwd_sel_e              w_rs_sel;
    fwd_sel_e              w_rt_sel;
    logic                  w_load_use;
    logic                  w_bubble;
    logic [DATA_WIDTH-1:0] w_fwd_rs;
    logic [DATA_WIDTH-1:0] w_fwd_rt;
    logic [DATA_WIDTH-1:0] w_sa_ext;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;

    fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
        .i_d_valid  (D_VALID),
        .i_rs_addr  (D_RS_ADDR),
        .i_rt_addr  (D_RT_ADDR),
        .i_use_rs   (D_USE_RS),
        .i_use_rt   (D_USE_RT),
        .i_e_valid  (r_valid),
        .i_e_wreg   (r_wreg),
        .i_e_m2reg  (r_m2reg),
        .i_e_rd     (r_rd),
        .i_m_wreg   (M_WREG),
        .i_m_rd     (M_RD),
        .o_rs_sel   (w_rs_sel),
        .o_rt_sel   (w_rt_sel),
        .o_load_use (w_load_use)
    );

    MUX_4x1_32bit #(.WIDTH(DATA_WIDTH)) u_mux_rs (
        .i_a0 (D_RS_DATA), .i_a1 (EX_RESULT), .i_a2 (M_RESULT), .i_a3 ('0),
        .i_sel(w_rs_sel),  .o_y  (w_fwd_rs)
    );

    MUX_4x1_32bit #(.WIDTH(DATA_WIDTH)) u_mux_rt (
        .i_a0 (D_RT_DATA), .i_a1 (EX_RESULT), .i_a2 (M_RESULT), .i_a3 ('0),
        .i_sel(w_rt_sel),  .o_y  (w_fwd_rt)
    );

    assign w_sa_ext = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, D_SA};

    MUX_2x1_32bit #(.WIDTH(DATA_WIDTH)) u_mux_a (
        .i_a0(w_fwd_rs), .i_a1(w_sa_ext), .i_sel(D_SHIFT), .o_y(w_op_a)
    );

    MUX_2x1_32bit #(.WIDTH(DATA_WIDTH)) u_mux_b (
        .i_a0(w_fwd_rt), .i_a1(D_IMM), .i_sel(D_ALUIMM), .o_y(w_op_b)
    );

    // A flushed instruction is dead, so its hazard must not freeze fetch.
    assign STALL    = HOLD | (w_load_use & ~FLUSH);
    assign w_bubble = FLUSH | w_load_use | ~D_VALID;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_store_data <= '0;
            r_aluc       <= '0;
            r_wreg       <= 1'b0;
            r_m2reg      <= 1'b0;
            r_wmem       <= 1'b0;
            r_rd         <= '0;
        end else if (!HOLD) begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_a          <= '0;
                r_b          <= '0;
                r_store_data <= '0;
                r_aluc       <= '0;
                r_wreg       <= 1'b0;
                r_m2reg      <= 1'b0;
                r_wmem       <= 1'b0;
                r_rd         <= '0;
            end else begin
                r_valid      <= 1'b1;
                r_a          <= w_op_a;
                r_b          <= w_op_b;
                r_store_data <= w_fwd_rt;
                r_aluc       <= D_ALUC;
                r_wreg       <= D_WREG;
                r_m2reg      <= D_M2REG;
                r_wmem       <= D_WMEM;
                r_rd         <= D_RD_ADDR;
            end
        end
    end

    assign E_VALID      = r_valid;
    assign E_A          = r_a;
    assign E_B          = r_b;
    assign E_STORE_DATA = r_store_data;
    assign E_ALUC       = r_aluc;
    assign E_WREG       = r_wreg;
    assign E_M2REG      = r_m2reg;
    assign E_WMEM       = r_wmem;
    assign E_RD         = r_rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus a randomized run,
// all checked against a next-state reference model of the EX slot.
module tb_id_ex_stage;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        D_VALID = 1'b0;
    logic [31:0] D_RS_DATA = '0, D_RT_DATA = '0, D_IMM = '0;
    logic [4:0]  D_RS_ADDR = '0, D_RT_ADDR = '0, D_RD_ADDR = '0, D_SA = '0;
    logic        D_USE_RS = 1'b0, D_USE_RT = 1'b0;
    logic [3:0]  D_ALUC = '0;
    logic        D_ALUIMM = 1'b0, D_SHIFT = 1'b0, D_WREG = 1'b0, D_M2REG = 1'b0, D_WMEM = 1'b0;
    logic [31:0] EX_RESULT = '0, M_RESULT = '0;
    logic        M_WREG = 1'b0;
    logic [4:0]  M_RD = '0;
    logic        FLUSH = 1'b0, HOLD = 1'b0;
    logic        STALL, E_VALID, E_WREG, E_M2REG, E_WMEM;
    logic [31:0] E_A, E_B, E_STORE_DATA;
    logic [3:0]  E_ALUC;
    logic [4:0]  E_RD;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .CLK(CLK), .RSTN(RSTN), .D_VALID(D_VALID),
        .D_RS_DATA(D_RS_DATA), .D_RT_DATA(D_RT_DATA),
        .D_RS_ADDR(D_RS_ADDR), .D_RT_ADDR(D_RT_ADDR), .D_RD_ADDR(D_RD_ADDR),
        .D_USE_RS(D_USE_RS), .D_USE_RT(D_USE_RT), .D_IMM(D_IMM), .D_SA(D_SA),
        .D_ALUC(D_ALUC), .D_ALUIMM(D_ALUIMM), .D_SHIFT(D_SHIFT), .D_WREG(D_WREG),
        .D_M2REG(D_M2REG), .D_WMEM(D_WMEM), .EX_RESULT(EX_RESULT),
        .M_WREG(M_WREG), .M_RD(M_RD), .M_RESULT(M_RESULT),
        .FLUSH(FLUSH), .HOLD(HOLD), .STALL(STALL), .E_VALID(E_VALID),
        .E_A(E_A), .E_B(E_B), .E_STORE_DATA(E_STORE_DATA), .E_ALUC(E_ALUC),
        .E_WREG(E_WREG), .E_M2REG(E_M2REG), .E_WMEM(E_WMEM), .E_RD(E_RD)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic [31:0] a, b, sd;
        logic [3:0]  aluc;
        logic        wreg, m2reg, wmem;
        logic [4:0]  rd;
    } est_t;

    est_t m = '0;  // model of what the EX slot should hold

    function automatic est_t obs();
        return {E_VALID, E_A, E_B, E_STORE_DATA, E_ALUC, E_WREG, E_M2REG, E_WMEM, E_RD};
    endfunction

    // Newest producer wins: an ALU result in EX, then MEM, then the register file.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (m.v && m.wreg && !m.m2reg && m.rd != 0 && m.rd == src) return EX_RESULT;
        if (M_WREG && M_RD != 0 && M_RD == src) return M_RESULT;
        return rf;
    endfunction

    function automatic logic lu();
        return D_VALID && m.v && m.wreg && m.m2reg && m.rd != 0 &&
               ((D_USE_RS && m.rd == D_RS_ADDR) || (D_USE_RT && m.rd == D_RT_ADDR));
    endfunction

    function automatic logic exp_stall();
        return HOLD || (lu() && !FLUSH);
    endfunction

    function automatic est_t model_next();
        est_t n;
        n = m;
        if (!RSTN) n = '0;
        else if (HOLD) n = m;
        else if (FLUSH || lu() || !D_VALID) n = '0;
        else begin
            n.v     = 1'b1;
            n.a     = D_SHIFT ? {27'd0, D_SA} : fwd(D_RS_ADDR, D_RS_DATA);
            n.b     = D_ALUIMM ? D_IMM : fwd(D_RT_ADDR, D_RT_DATA);
            n.sd    = fwd(D_RT_ADDR, D_RT_DATA);
            n.aluc  = D_ALUC;
            n.wreg  = D_WREG;
            n.m2reg = D_M2REG;
            n.wmem  = D_WMEM;
            n.rd    = D_RD_ADDR;
        end
        return n;
    endfunction

    task automatic clk_edge();
        est_t nx;
        nx = model_next();
        @(posedge CLK);
        #1;
        m = nx;
    endtask

    task automatic rand_dec();
        D_VALID   = 1'b1;
        D_RS_DATA = $urandom;
        D_RT_DATA = $urandom;
        D_IMM     = $urandom;
        D_RS_ADDR = 5'($urandom_range(0, 3));
        D_RT_ADDR = 5'($urandom_range(0, 3));
        D_RD_ADDR = 5'($urandom_range(0, 3));
        D_SA      = 5'($urandom);
        D_ALUC    = 4'($urandom);
        D_USE_RS  = 1'($urandom);
        D_USE_RT  = 1'($urandom);
        D_ALUIMM  = 1'($urandom);
        D_SHIFT   = 1'($urandom);
        D_WREG    = 1'($urandom);
        D_M2REG   = 1'($urandom);
        D_WMEM    = 1'($urandom);
    endtask

    task automatic test_reset();
        RSTN = 1'b0; HOLD = 1'b0; FLUSH = 1'b0; M_WREG = 1'b0;
        rand_dec();
        repeat (2) clk_edge();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs()); end
        checks++;
        if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", STALL); end
        RSTN = 1'b1;
        rand_dec();
        clk_edge();
        checks++;
        if (E_VALID !== 1'b1) begin errors++; $display("FAIL reset_first_cap got=%b exp=1", E_VALID); end
        checks++;
        if (obs() !== m) begin errors++; $display("FAIL reset_first_state got=%h exp=%h", obs(), m); end
    endtask

    task automatic test_ex_forward();
        rand_dec();
        D_RD_ADDR = 5'd3; D_WREG = 1'b1; D_M2REG = 1'b0; D_USE_RS = 1'b0; D_USE_RT = 1'b0;
        M_WREG = 1'b0;
        clk_edge();
        checks++;
        if (E_RD !== 5'd3 || E_WREG !== 1'b1) begin
            errors++; $display("FAIL exfwd_setup got rd=%0d wreg=%b exp rd=3 wreg=1", E_RD, E_WREG);
        end
        rand_dec();
        D_RS_ADDR = 5'd3; D_SHIFT = 1'b0; D_RS_DATA = 32'h1111_1111; D_USE_RS = 1'b1;
        EX_RESULT = 32'h0000_00AA;
        M_WREG = 1'b1; M_RD = 5'd3; M_RESULT = 32'h0000_00BB;
        clk_edge();
        checks++;
        if (E_A !== 32'h0000_00AA) begin errors++; $display("FAIL exfwd_A got=%h exp=000000aa", E_A); end
        checks++;
        if (obs() !== m) begin errors++; $display("FAIL exfwd_state got=%h exp=%h", obs(), m); end
    endtask

    task automatic test_load_use();
        rand_dec();
        D_RD_ADDR = 5'd5; D_WREG = 1'b1; D_M2REG = 1'b1; D_USE_RS = 1'b0; D_USE_RT = 1'b0;
        M_WREG = 1'b0;
        clk_edge();
        rand_dec();
        D_RS_ADDR = 5'd1; D_RT_ADDR = 5'd5; D_USE_RT = 1'b1; D_ALUIMM = 1'b0;
        #1;
        checks++;
        if (STALL !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", STALL); end
        clk_edge();
        checks++;
        if (E_VALID !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", E_VALID); end
        checks++;
        if (STALL !== 1'b0) begin errors++; $display("FAIL lu_stall_once got=%b exp=0", STALL); end
        M_WREG = 1'b1; M_RD = 5'd5; M_RESULT = 32'hDEAD_BEEF;
        clk_edge();
        checks++;
        if (E_B !== 32'hDEAD_BEEF || E_VALID !== 1'b1) begin
            errors++; $display("FAIL lu_memfwd got B=%h v=%b exp B=deadbeef v=1", E_B, E_VALID);
        end
    endtask

    task automatic test_r0();
        rand_dec();
        D_RD_ADDR = 5'd0; D_WREG = 1'b1; D_M2REG = 1'b0; D_USE_RS = 1'b0; D_USE_RT = 1'b0;
        M_WREG = 1'b0;
        clk_edge();
        rand_dec();
        D_RS_ADDR = 5'd0; D_RS_DATA = 32'd0; D_SHIFT = 1'b0;
        D_RD_ADDR = 5'd0; D_M2REG = 1'b0;
        EX_RESULT = 32'hFFFF_FFFF;
        M_WREG = 1'b1; M_RD = 5'd0; M_RESULT = 32'h0000_CAFE;
        clk_edge();
        checks++;
        if (E_A !== 32'd0) begin errors++; $display("FAIL r0_guard got=%h exp=0", E_A); end
    endtask

    task automatic test_shift_imm();
        rand_dec();
        D_SHIFT = 1'b1; D_SA = 5'd7; D_ALUIMM = 1'b1; D_IMM = 32'h0000_1234;
        D_RT_ADDR = 5'd9;
        M_WREG = 1'b1; M_RD = 5'd9; M_RESULT = 32'h0000_55AA;
        clk_edge();
        checks++;
        if (E_A !== 32'd7 || E_B !== 32'h0000_1234 || E_STORE_DATA !== 32'h0000_55AA) begin
            errors++;
            $display("FAIL shift_imm got A=%h B=%h SD=%h exp A=00000007 B=00001234 SD=000055aa",
                     E_A, E_B, E_STORE_DATA);
        end
        checks++;
        if (obs() !== m) begin errors++; $display("FAIL shift_imm_state got=%h exp=%h", obs(), m); end
    endtask

    task automatic test_flush_hold();
        est_t saved;
        rand_dec();
        D_RD_ADDR = 5'd6; D_WREG = 1'b1; D_M2REG = 1'b1; D_USE_RS = 1'b0; D_USE_RT = 1'b0;
        M_WREG = 1'b0;
        clk_edge();
        rand_dec();
        D_RS_ADDR = 5'd6; D_USE_RS = 1'b1; FLUSH = 1'b1;
        #1;
        checks++;
        if (STALL !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", STALL); end
        clk_edge();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL flush_bubble got=%h exp=0", obs()); end
        FLUSH = 1'b0;
        rand_dec();
        clk_edge();
        saved = obs();
        checks++;
        if (saved !== m || saved.v !== 1'b1) begin
            errors++; $display("FAIL hold_setup got=%h exp=%h", saved, m);
        end
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_dec();
            #1;
            checks++;
            if (STALL !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, STALL); end
            clk_edge();
            checks++;
            if (obs() !== saved) begin errors++; $display("FAIL hold_keep[%0d] got=%h exp=%h", i, obs(), saved); end
        end
        RSTN = 1'b0;
        clk_edge();
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL hold_reset got=%h exp=0", obs()); end
        checks++;
        if (STALL !== 1'b1) begin errors++; $display("FAIL hold_reset_stall got=%b exp=1", STALL); end
        HOLD = 1'b0;
        RSTN = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rand_dec();
            D_VALID   = ($urandom_range(0, 5) != 0);
            RSTN      = ($urandom_range(0, 31) != 0);
            HOLD      = ($urandom_range(0, 7) == 0);
            FLUSH     = ($urandom_range(0, 7) == 0);
            EX_RESULT = $urandom;
            M_WREG    = 1'($urandom);
            M_RD      = 5'($urandom_range(0, 3));
            M_RESULT  = $urandom;
            #1;
            checks++;
            if (STALL !== exp_stall()) begin
                errors++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, STALL, exp_stall());
            end
            clk_edge();
            checks++;
            if (obs() !== m) begin errors++; $display("FAIL rnd_state[%0d] got=%h exp=%h", i, obs(), m); end
        end
        RSTN = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_ex_forward();
        test_load_use();
        test_r0();
        test_shift_imm();
        test_flush_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
